// File: rtl/bw_rf_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bw_rf_fifo_pkg
// Description : Shared constants and helpers for the bw_rf_fifo register-file
//               FIFO (default geometry and modulo pointer increment).
// Revision    : 1.0 - initial release
// ============================================================================
package bw_rf_fifo_pkg;

    // Default geometry: 64 data bits + parity, 16 entries total.
    localparam int c_WIDTH_DEF = 65;
    localparam int c_DEPTH_DEF = 16;
    localparam int c_AFULL_DEF = 12;

    // Pointer increment that wraps back to 0 after the last valid index.
    // The array holds DEPTH-1 entries, so the wrap point is not a power of
    // two and cannot rely on natural binary rollover.
    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned last);
        return (ptr == last) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bw_rf_fifo_ary.sv
`default_nettype none
// ============================================================================
// Module      : bw_rf_fifo_ary
// Description : WIDTH x ENTRIES flop array, one synchronous write port and one
//               combinational read port. No reset: contents are only ever
//               read after being written.
// Ports       : rclk  - clock
//               wr_en - write strobe
//               wr_a  - write address
//               di    - write data
//               rd_a  - read address
//               dout  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module bw_rf_fifo_ary #(
    parameter int WIDTH   = 65,
    parameter int ENTRIES = 15,
    parameter int AW      = 4
) (
    input  logic             rclk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_a,
    input  logic [WIDTH-1:0] di,
    input  logic [AW-1:0]    rd_a,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_mem [ENTRIES];

    // Per-row write decode keeps every write in range even though the
    // address space (2**AW) is larger than the row count.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_row
        always_ff @(posedge rclk) begin
            if (wr_en && (wr_a == AW'(g))) begin
                r_mem[g] <= di;
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (rd_a == AW'(i)) begin
                dout = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bw_rf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bw_rf_fifo
// Description : Single-clock register-file FIFO with ready/valid handshakes.
//               DEPTH-1 entry flop array plus one registered output stage.
//               A push into an empty FIFO bypasses the array and lands in the
//               output register, visible one cycle later.
// Ports       : rclk        - clock
//               arst_l      - asynchronous active-low reset
//               clr         - synchronous flush (overrides push/pop/hold)
//               hold        - freeze all state, suppress handshakes
//               testmux_sel - combinational test bypass, di -> dout
//               wr_vld/wr_rdy/di   - push handshake and data
//               rd_rdy/do_vld/dout - pop handshake and head data
//                             (head data is named dout: "do" is reserved)
//               count/empty/full/afull - registered occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module bw_rf_fifo
    import bw_rf_fifo_pkg::*;
#(
    parameter  int WIDTH        = c_WIDTH_DEF,
    parameter  int DEPTH        = c_DEPTH_DEF,
    parameter  int AFULL_THRESH = c_AFULL_DEF,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             clr,
    input  logic             hold,
    input  logic             testmux_sel,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] di,
    input  logic             rd_rdy,
    output logic             do_vld,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             afull
);

    localparam int          c_ENTRIES   = DEPTH - 1;
    localparam int unsigned c_LAST      = DEPTH - 2;
    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_AFULL_CNT = (AW+1)'(AFULL_THRESH);

    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             r_do_vld;
    logic [WIDTH-1:0] r_do;
    logic             r_empty;
    logic             r_full;
    logic             r_afull;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_ary_cnt;
    logic             w_ary_empty;
    logic             w_out_free;
    logic             w_load_ary;
    logic             w_bypass;
    logic             w_ary_wr;
    logic [WIDTH-1:0] w_ary_dout;
    logic [AW:0]      w_count_nxt;
    logic [AW-1:0]    w_rd_ptr_inc;
    logic [AW-1:0]    w_wr_ptr_inc;

    assign wr_rdy = ~r_full & ~hold;
    assign w_push = wr_vld & wr_rdy;
    assign w_pop  = r_do_vld & rd_rdy & ~hold;

    // Entries held in the array alone (the output register is one of count).
    assign w_ary_cnt   = r_count - (AW+1)'(r_do_vld);
    assign w_ary_empty = (w_ary_cnt == '0);

    // The output register can take a new head this cycle.
    assign w_out_free = ~r_do_vld | w_pop;
    assign w_load_ary = w_out_free & ~w_ary_empty & ~hold;
    assign w_bypass   = w_out_free & w_ary_empty & w_push;
    assign w_ary_wr   = w_push & ~w_bypass & ~clr;

    assign w_count_nxt  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_rd_ptr_inc = AW'(wrap_inc(32'(r_rd_ptr), c_LAST));
    assign w_wr_ptr_inc = AW'(wrap_inc(32'(r_wr_ptr), c_LAST));

    bw_rf_fifo_ary #(
        .WIDTH   (WIDTH),
        .ENTRIES (c_ENTRIES),
        .AW      (AW)
    ) u_ary (
        .rclk  (rclk),
        .wr_en (w_ary_wr),
        .wr_a  (r_wr_ptr),
        .di    (di),
        .rd_a  (r_rd_ptr),
        .dout  (w_ary_dout)
    );

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_do_vld <= 1'b0;
            r_do     <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
        end else if (clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_do_vld <= 1'b0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
        end else if (!hold) begin
            r_count <= w_count_nxt;
            // Status flags come straight from flops so they never glitch.
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_DEPTH_CNT);
            r_afull <= (w_count_nxt >= c_AFULL_CNT);
            if (w_out_free) begin
                r_do_vld <= w_load_ary | w_bypass;
                if (w_load_ary) begin
                    r_do <= w_ary_dout;
                end else if (w_bypass) begin
                    r_do <= di;
                end
            end
            if (w_load_ary) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_ary_wr) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
        end
    end

    assign do_vld = testmux_sel ? wr_vld : r_do_vld;
    assign dout   = testmux_sel ? di : r_do;
    assign count  = r_count;
    assign empty  = r_empty;
    assign full   = r_full;
    assign afull  = r_afull;

endmodule
`default_nettype wire

// File: tb/tb_bw_rf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bw_rf_fifo
// Description : Self-checking bench for bw_rf_fifo. A queue model tracks the
//               FIFO contents; outputs are compared against it every cycle,
//               with directed sequences plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bw_rf_fifo;

    localparam int c_WIDTH = 65;
    localparam int c_DEPTH = 16;
    localparam int c_AFULL = 12;
    localparam int c_AW    = $clog2(c_DEPTH);

    logic               rclk = 1'b0;
    logic               arst_l;
    logic               clr;
    logic               hold;
    logic               testmux_sel;
    logic               wr_vld;
    logic               wr_rdy;
    logic [c_WIDTH-1:0] di;
    logic               rd_rdy;
    logic               do_vld;
    logic [c_WIDTH-1:0] dout;
    logic [c_AW:0]      count;
    logic               empty;
    logic               full;
    logic               afull;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [c_WIDTH-1:0] m_q[$];
    bit                 m_push;
    bit                 m_pop;
    int                 m_n;

    always #5 rclk = ~rclk;

    bw_rf_fifo #(
        .WIDTH        (c_WIDTH),
        .DEPTH        (c_DEPTH),
        .AFULL_THRESH (c_AFULL)
    ) dut (
        .rclk        (rclk),
        .arst_l      (arst_l),
        .clr         (clr),
        .hold        (hold),
        .testmux_sel (testmux_sel),
        .wr_vld      (wr_vld),
        .wr_rdy      (wr_rdy),
        .di          (di),
        .rd_rdy      (rd_rdy),
        .do_vld      (do_vld),
        .dout        (dout),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .afull       (afull)
    );

    task automatic chk(input string name, input logic [c_WIDTH-1:0] act,
                       input logic [c_WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is simply an ordered queue of accepted data.
    always @(posedge rclk) begin
        if (arst_l) begin
            m_push = wr_vld && (m_q.size() < c_DEPTH) && !hold;
            m_pop  = (m_q.size() != 0) && rd_rdy && !hold;
            if (clr) begin
                m_q.delete();
            end else begin
                if (m_pop)  void'(m_q.pop_front());
                if (m_push) m_q.push_back(di);
            end
        end
    end

    always @(negedge arst_l) m_q.delete();

    // Per-cycle comparison against the model.
    always @(negedge rclk) begin
        if (chk_en && arst_l) begin
            m_n = m_q.size();
            chk("count", c_WIDTH'(count), c_WIDTH'(m_n));
            chk("empty", c_WIDTH'(empty), c_WIDTH'(m_n == 0));
            chk("full",  c_WIDTH'(full),  c_WIDTH'(m_n == c_DEPTH));
            chk("afull", c_WIDTH'(afull), c_WIDTH'(m_n >= c_AFULL));
            chk("wr_rdy", c_WIDTH'(wr_rdy), c_WIDTH'((m_n < c_DEPTH) && !hold));
            if (testmux_sel) begin
                chk("tm_do_vld", c_WIDTH'(do_vld), c_WIDTH'(wr_vld));
                chk("tm_do", dout, di);
            end else begin
                chk("do_vld", c_WIDTH'(do_vld), c_WIDTH'(m_n != 0));
                if (m_n != 0) chk("do", dout, m_q[0]);
            end
        end
    end

    // Apply inputs, then advance through one rising edge to just past the
    // following falling edge (after the compare process has sampled).
    task automatic drive(input logic wv, input logic [c_WIDTH-1:0] d,
                         input logic rr, input logic h, input logic c,
                         input logic tm);
        wr_vld = wv; di = d; rd_rdy = rr; hold = h; clr = c; testmux_sel = tm;
        @(negedge rclk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("drain_empty", c_WIDTH'(empty), c_WIDTH'(1));
    endtask

    function automatic logic [c_WIDTH-1:0] rnd_data();
        return {1'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    initial begin
        arst_l = 1'b0; clr = 1'b0; hold = 1'b0; testmux_sel = 1'b0;
        wr_vld = 1'b0; rd_rdy = 1'b0; di = '0;
        #12;
        chk("rst_count",  c_WIDTH'(count),  c_WIDTH'(0));
        chk("rst_empty",  c_WIDTH'(empty),  c_WIDTH'(1));
        chk("rst_full",   c_WIDTH'(full),   c_WIDTH'(0));
        chk("rst_afull",  c_WIDTH'(afull),  c_WIDTH'(0));
        chk("rst_do_vld", c_WIDTH'(do_vld), c_WIDTH'(0));
        chk("rst_do",     dout,             c_WIDTH'(0));
        #5 arst_l = 1'b1;
        @(negedge rclk); #1;
        chk("rst_wr_rdy", c_WIDTH'(wr_rdy), c_WIDTH'(1));
        chk_en = 1'b1;

        // Single push into empty FIFO: visible one cycle later.
        drive(1'b1, 65'h1_0000_0000_0000_00AA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_do_vld", c_WIDTH'(do_vld), c_WIDTH'(1));
        chk("first_do",     dout, 65'h1_0000_0000_0000_00AA);
        chk("first_count",  c_WIDTH'(count), c_WIDTH'(1));
        chk("first_empty",  c_WIDTH'(empty), c_WIDTH'(0));
        drain();

        // Fill to full, overflow attempt, then drain in order.
        for (int i = 0; i < c_DEPTH; i++) begin
            drive(1'b1, c_WIDTH'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            chk("fill_afull", c_WIDTH'(afull), c_WIDTH'(i + 1 >= 12));
        end
        chk("fill_full",   c_WIDTH'(full),   c_WIDTH'(1));
        chk("fill_wr_rdy", c_WIDTH'(wr_rdy), c_WIDTH'(0));
        drive(1'b1, c_WIDTH'(99), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("overflow_count", c_WIDTH'(count), c_WIDTH'(16));
        for (int i = 0; i < c_DEPTH; i++) begin
            chk("drain_order", dout, c_WIDTH'(i));
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("drained_empty", c_WIDTH'(empty), c_WIDTH'(1));

        // Steady state at count 8 with push+pop every cycle.
        for (int i = 0; i < 8; i++) drive(1'b1, c_WIDTH'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, c_WIDTH'(108 + k), 1'b1, 1'b0, 1'b0, 1'b0);
            chk("steady_count", c_WIDTH'(count), c_WIDTH'(8));
            chk("steady_do", dout, c_WIDTH'(101 + k));
        end
        drain();

        // Hold freezes everything.
        for (int i = 0; i < 5; i++) drive(1'b1, c_WIDTH'(200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, c_WIDTH'(300 + k), 1'b1, 1'b1, 1'b0, 1'b0);
            chk("hold_count",  c_WIDTH'(count),  c_WIDTH'(5));
            chk("hold_do",     dout,             c_WIDTH'(200));
            chk("hold_wr_rdy", c_WIDTH'(wr_rdy), c_WIDTH'(0));
        end
        drain();

        // Flush with a concurrent push.
        for (int i = 0; i < 6; i++) drive(1'b1, c_WIDTH'(400 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, c_WIDTH'(77), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_count",  c_WIDTH'(count),  c_WIDTH'(0));
        chk("clr_do_vld", c_WIDTH'(do_vld), c_WIDTH'(0));
        chk("clr_empty",  c_WIDTH'(empty),  c_WIDTH'(1));
        drive(1'b1, c_WIDTH'(85), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_clr_do_vld", c_WIDTH'(do_vld), c_WIDTH'(1));
        chk("post_clr_do",     dout, c_WIDTH'(85));
        drain();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom % 4) != 0, rnd_data(), ($urandom % 3) != 0,
                  ($urandom % 16) == 0, ($urandom % 128) == 0,
                  ($urandom % 32) == 0);
        end

        // Asynchronous reset mid-stream at count 9.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_arst_count", c_WIDTH'(count), c_WIDTH'(9));
        wr_vld = 1'b0;
        #2 arst_l = 1'b0;
        #1;
        chk("arst_count",  c_WIDTH'(count),  c_WIDTH'(0));
        chk("arst_do_vld", c_WIDTH'(do_vld), c_WIDTH'(0));
        chk("arst_do",     dout,             c_WIDTH'(0));
        chk("arst_empty",  c_WIDTH'(empty),  c_WIDTH'(1));
        #10 arst_l = 1'b1;

        // Combinational test bypass.
        testmux_sel = 1'b1; wr_vld = 1'b1; di = 65'h1_2345_6789_ABCD_EF01;
        #1;
        chk("tm_do_a",     dout, 65'h1_2345_6789_ABCD_EF01);
        chk("tm_do_vld_a", c_WIDTH'(do_vld), c_WIDTH'(1));
        di = 65'h0_0F0F_F0F0_5A5A_A5A5; wr_vld = 1'b0;
        #1;
        chk("tm_do_b",     dout, 65'h0_0F0F_F0F0_5A5A_A5A5);
        chk("tm_do_vld_b", c_WIDTH'(do_vld), c_WIDTH'(0));
        testmux_sel = 1'b0;
        @(negedge rclk); #1;
        for (int k = 0; k < 200; k++) begin
            drive(($urandom % 2) != 0, rnd_data(), ($urandom % 2) != 0,
                  1'b0, 1'b0, 1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
